// File: rtl/layer_out_serializer_pkg.sv
// Shared defaults, read-side state encoding and sizing helper for the
// layer output serializer and its storage banks.
package layer_out_serializer_pkg;

  localparam int DEF_DATA_WIDTH  = 16;
  localparam int DEF_NUM_NEURONS = 30;
  localparam int DEF_LANES       = 1;
  localparam int DEF_CNT_WIDTH   = 16;

  // Read side: IDLE while the bank at rd_ptr is empty, SEND while it streams.
  typedef enum logic [0:0] {
    RD_IDLE = 1'b0,
    RD_SEND = 1'b1
  } rd_state_e;

  // Width of a beat index; a one-beat vector still gets a 1-bit index.
  function automatic int index_width(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/layer_out_bank.sv
// One storage bank: holds a whole neuron vector and presents one beat
// (LANES consecutive neuron values) selected by rd_index.
module layer_out_bank
  import layer_out_serializer_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int NUM_NEURONS = DEF_NUM_NEURONS,
  parameter int LANES       = DEF_LANES,
  parameter int IDX_W       = index_width(DEF_NUM_NEURONS / DEF_LANES)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              wr_en,
  input  logic [NUM_NEURONS*DATA_WIDTH-1:0] wr_data,
  input  logic [IDX_W-1:0]                  rd_index,
  output logic [LANES*DATA_WIDTH-1:0]       rd_data
);

  localparam int VEC_W  = NUM_NEURONS * DATA_WIDTH;
  localparam int BEAT_W = LANES * DATA_WIDTH;

  logic [VEC_W-1:0] bank_r;

  // Capture the whole vector when this bank is the write target.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank_r <= '0;
    end else if (wr_en) begin
      bank_r <= wr_data;
    end else begin
      bank_r <= bank_r;
    end
  end

  // Lane-select mux: beat k covers neurons k*LANES .. k*LANES+LANES-1.
  always_comb begin
    rd_data = bank_r[int'(rd_index) * BEAT_W +: BEAT_W];
  end

endmodule

// File: rtl/layer_out_serializer.sv
// Double-buffered parallel-to-serial converter between neuron layers.
// Vectors are captured whole into one of two banks and streamed out
// LANES values per beat with ready/valid handshaking; a vector arriving
// while both banks are occupied is dropped and counted.
module layer_out_serializer
  import layer_out_serializer_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int NUM_NEURONS = DEF_NUM_NEURONS,
  parameter int LANES       = DEF_LANES,
  parameter int CNT_WIDTH   = DEF_CNT_WIDTH
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          in_valid,
  input  logic [NUM_NEURONS*DATA_WIDTH-1:0]             in_data,
  output logic [LANES*DATA_WIDTH-1:0]                   out_data,
  output logic                                          out_valid,
  input  logic                                          out_ready,
  output logic                                          out_last,
  output logic [index_width(NUM_NEURONS/LANES)-1:0]     out_index,
  output logic                                          busy,
  output logic                                          overflow,
  output logic [CNT_WIDTH-1:0]                          drop_count
);

  localparam int BEATS  = NUM_NEURONS / LANES;
  localparam int IDX_W  = index_width(BEATS);
  localparam int BEAT_W = LANES * DATA_WIDTH;
  localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(BEATS - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};

  // Registered state
  rd_state_e             state_r;
  logic [1:0]            full_r;
  logic                  wr_ptr_r;
  logic                  rd_ptr_r;
  logic [IDX_W-1:0]      idx_r;
  logic [BEAT_W-1:0]     out_data_r;
  logic                  out_valid_r;
  logic                  out_last_r;
  logic                  busy_r;
  logic                  overflow_r;
  logic [CNT_WIDTH-1:0]  drop_count_r;

  // Next-state terms
  logic                  xfer_s;
  logic                  free_s;
  logic                  capture_s;
  logic                  drop_s;
  logic                  bypass_s;
  logic [1:0]            wr_en_s;
  logic [1:0]            full_next_s;
  logic                  wr_ptr_next_s;
  logic                  rd_ptr_next_s;
  logic [IDX_W-1:0]      idx_next_s;
  rd_state_e             state_next_s;
  logic [BEAT_W-1:0]     out_data_next_s;
  logic [BEAT_W-1:0]     rd_data_s [2];

  for (genvar b = 0; b < 2; b++) begin : g_bank
    layer_out_bank #(
      .DATA_WIDTH  (DATA_WIDTH),
      .NUM_NEURONS (NUM_NEURONS),
      .LANES       (LANES),
      .IDX_W       (IDX_W)
    ) u_bank (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (wr_en_s[b]),
      .wr_data  (in_data),
      .rd_index (idx_next_s),
      .rd_data  (rd_data_s[b])
    );
  end

  // Handshake, bank occupancy, pointer and beat-index next-state logic.
  always_comb begin
    xfer_s    = (state_r == RD_SEND) && out_ready;
    free_s    = xfer_s && (idx_r == LAST_IDX);
    // With two ping-pong banks, full[wr_ptr] is set only when both are occupied.
    capture_s = in_valid && !full_r[wr_ptr_r];
    drop_s    = in_valid && full_r[wr_ptr_r];

    wr_en_s = 2'b00;
    if (capture_s) begin
      wr_en_s[wr_ptr_r] = 1'b1;
    end else begin
      wr_en_s = 2'b00;
    end

    // Freed and captured banks are always different banks in the same cycle.
    full_next_s = full_r;
    if (free_s) begin
      full_next_s[rd_ptr_r] = 1'b0;
    end else begin
      full_next_s[rd_ptr_r] = full_r[rd_ptr_r];
    end
    if (capture_s) begin
      full_next_s[wr_ptr_r] = 1'b1;
    end else begin
      full_next_s[wr_ptr_r] = full_next_s[wr_ptr_r];
    end

    wr_ptr_next_s = capture_s ? ~wr_ptr_r : wr_ptr_r;
    rd_ptr_next_s = free_s    ? ~rd_ptr_r : rd_ptr_r;

    if (free_s) begin
      idx_next_s = '0;
    end else if (xfer_s) begin
      idx_next_s = idx_r + 1'b1;
    end else begin
      idx_next_s = idx_r;
    end

    state_next_s = full_next_s[rd_ptr_next_s] ? RD_SEND : RD_IDLE;
  end

  // Next beat data; a bank being written this edge is read from in_data
  // directly so beat 0 appears the cycle after capture.
  always_comb begin
    bypass_s = capture_s && (wr_ptr_r == rd_ptr_next_s);
    if (state_next_s == RD_SEND) begin
      if (bypass_s) begin
        out_data_next_s = in_data[BEAT_W-1:0];
      end else begin
        out_data_next_s = rd_data_s[rd_ptr_next_s];
      end
    end else begin
      out_data_next_s = '0;
    end
  end

  // Read FSM with pointers, bank flags and registered stream outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= RD_IDLE;
      full_r      <= 2'b00;
      wr_ptr_r    <= 1'b0;
      rd_ptr_r    <= 1'b0;
      idx_r       <= '0;
      out_data_r  <= '0;
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      full_r      <= full_next_s;
      wr_ptr_r    <= wr_ptr_next_s;
      rd_ptr_r    <= rd_ptr_next_s;
      idx_r       <= idx_next_s;
      out_data_r  <= out_data_next_s;
      busy_r      <= |full_next_s;
      case (state_next_s)
        RD_SEND: begin
          state_r     <= RD_SEND;
          out_valid_r <= 1'b1;
          out_last_r  <= (idx_next_s == LAST_IDX);
        end
        RD_IDLE: begin
          state_r     <= RD_IDLE;
          out_valid_r <= 1'b0;
          out_last_r  <= 1'b0;
        end
        default: begin
          state_r     <= RD_IDLE;
          out_valid_r <= 1'b0;
          out_last_r  <= 1'b0;
        end
      endcase
    end
  end

  // Sticky overflow flag and saturating count of dropped vectors.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_r   <= 1'b0;
      drop_count_r <= '0;
    end else if (drop_s) begin
      overflow_r   <= 1'b1;
      drop_count_r <= (drop_count_r == CNT_MAX) ? drop_count_r : drop_count_r + 1'b1;
    end else begin
      overflow_r   <= overflow_r;
      drop_count_r <= drop_count_r;
    end
  end

  assign out_data   = out_data_r;
  assign out_valid  = out_valid_r;
  assign out_last   = out_last_r;
  assign out_index  = idx_r;
  assign busy       = busy_r;
  assign overflow   = overflow_r;
  assign drop_count = drop_count_r;

endmodule
